storage_access_arbiter: RTL and testbench
=========================================

// Module: storage_access_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer sharing one single-port storage array between two requesters.
//   Requesters: 0 = switch panel, 1 = CPU datapath.
//   Serialises requests into single storage accesses and drives the storage enable, write, address and data lines.
//   Returns read data to the winning requester with a valid pulse.
//   Sits between the requesters and the Storage array.
// PARAMETERS
//   DATA_W    32  storage word width
//   ADDR_W    6   storage address width (2**ADDR_W words)
//   FIXED_PRI 0   0 = round-robin; 1 = requester 0 always wins on conflict
// PORTS
//   CLK        in   1       clock, rising edge
//   RST_n      in   1       synchronous reset, active-low
//   Req0/Req1  in   1       access request; held high until matching Gnt seen
//   We0/We1    in   1       1 = write, 0 = read; valid while Req high
//   Addr0/1    in   ADDR_W  word address; valid while Req high
//   Wdata0/1   in   DATA_W  write data; valid while Req high and We=1
//   Gnt0/Gnt1  out  1       one-cycle grant pulse, in ISSUE cycle
//   Rvalid0/1  out  1       one-cycle pulse: Rdata0/1 valid
//   Rdata0/1   out  DATA_W  read data, holds last value until next read for that port
//   Mem_En     out  1       storage access enable
//   Mem_We     out  1       storage write enable (only meaningful with Mem_En)
//   Mem_Addr   out  ADDR_W  storage address
//   Mem_Wdata  out  DATA_W  storage write data
//   Mem_Rdata  in   DATA_W  storage read data, valid the cycle after Mem_En=1, Mem_We=0
//   Busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//   - All outputs registered.
//   - Reset value of every output = 0; state = IDLE; Last = 1 (requester 0 favoured first).
//   - FSM states: IDLE, ISSUE, RD_WAIT.
//   - IDLE, no Req: stay IDLE.
//   - IDLE, any Req:
//       - Winner = sole requester.
//       - Both requesting: winner = requester != Last (FIXED_PRI=1: requester 0).
//       - Capture winner's We/Addr/Wdata; Last <= winner.
//       - Next: ISSUE.
//   - ISSUE (exactly 1 cycle):
//       - Mem_En = 1; Mem_We/Mem_Addr/Mem_Wdata = captured values.
//       - Gnt<winner> = 1.
//       - Write -> IDLE. Read -> RD_WAIT.
//   - RD_WAIT (1 cycle):
//       - Mem_En = 0.
//       - Sample Mem_Rdata into Rdata<winner>; Rvalid<winner> = 1 in the following cycle (IDLE).
//   - Mem_En, Gnt* and Rvalid* are never high for more than 1 consecutive cycle.
//   - Mem_En, Gnt* and Rvalid* are never high for both requesters at once.
//   - Latency, Req rises in cycle T (state IDLE):
//       - Gnt and Mem_En in T+1.
//       - Write complete at end of T+1.
//       - Read: Mem_Rdata sampled in T+2; Rvalid in T+3.
//   - Throughput: 1 write per 2 cycles; 1 read per 3 cycles.
//   - Rvalid cycle overlaps the next IDLE cycle: a new arbitration may start in the same cycle.
//   - Req seen in the cycle after Gnt counts as a new request. Registered requesters drop Req on the edge that samples Gnt.
//   - Req changes outside IDLE: ignored.
//   - Wdata/Addr changes after capture: do not affect the access in flight.
//   - Mem_Addr/Mem_We/Mem_Wdata hold their last values when Mem_En=0.
//   - Reset mid-operation (any state):
//       - Return to IDLE; all outputs cleared next cycle; Last = 1.
//       - In-flight access dropped: no Gnt/Rvalid issued for it.
//       - A write already in ISSUE is considered performed.
//   - Address width exact: no wrap or arithmetic on Addr; out-of-range is impossible by width.
// TESTING
//   1. Reset: RST_n=0 for 2 cycles with Req0=Req1=1 -> all outputs 0, Busy=0 throughout reset.
//   2. Single write then read:
//        - Req0, We0=1, Addr0=6'h03, Wdata0=32'h0000_0003 -> Gnt0 and Mem_En/Mem_We at T+1.
//        - Then read of 6'h03 -> Rvalid0 at T+3 with Rdata0=32'h0000_0003.
//   3. Contention, FIXED_PRI=0, Req0=Req1=1 held, all writes, addrs 0..3:
//        - Grants alternate 0,1,0,1, starting with 0.
//        - Gnt pulses spaced 2 cycles apart.
//   4. FIXED_PRI=1, both requesting continuously:
//        - Requester 0 granted every time.
//        - Requester 1 granted only once Req0 drops.
//   5. Reset in RD_WAIT: RST_n=0 during requester 1 read -> no Rvalid1; Busy=0 next cycle.
//   6. Data stability:
//        - Change Addr1/Wdata1 in the ISSUE cycle -> Mem_Addr/Mem_Wdata keep the captured values.
//        - Model storage holds the old data.

Source files
------------

// File: rtl/storage_access_arbiter_if.sv
// Requester and storage bus bundle for the two-port storage access arbiter.
// The arbiter uses the slave view; requesters and the storage model use the master view.
interface storage_access_arbiter_if #(
    parameter int unsigned DataW = 32,
    parameter int unsigned AddrW = 6
);
    logic             req0;
    logic             req1;
    logic             we0;
    logic             we1;
    logic [AddrW-1:0] addr0;
    logic [AddrW-1:0] addr1;
    logic [DataW-1:0] wdata0;
    logic [DataW-1:0] wdata1;
    logic             gnt0;
    logic             gnt1;
    logic             rvalid0;
    logic             rvalid1;
    logic [DataW-1:0] rdata0;
    logic [DataW-1:0] rdata1;
    logic             mem_en;
    logic             mem_we;
    logic [AddrW-1:0] mem_addr;
    logic [DataW-1:0] mem_wdata;
    logic [DataW-1:0] mem_rdata;
    logic             busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/storage_access_arbiter.sv
// Two-requester arbiter sharing one single-port storage array; all outputs registered.
// Requester 0 is the switch panel, requester 1 the CPU datapath.
module storage_access_arbiter #(
    parameter int unsigned DataW    = 32,
    parameter int unsigned AddrW    = 6,
    parameter bit          FixedPri = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    storage_access_arbiter_if.slave  bus_io
);

    typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;

    state_e           state_q;
    logic             last_q;
    logic             winner;
    logic [1:0]       gnt_q;
    logic [1:0]       rvalid_q;
    logic [DataW-1:0] rdata0_q;
    logic [DataW-1:0] rdata1_q;
    logic             mem_en_q;
    logic             mem_we_q;
    logic [AddrW-1:0] mem_addr_q;
    logic [DataW-1:0] mem_wdata_q;
    logic             busy_q;

    // On conflict the requester that did not win last time goes next.
    always_comb begin
        winner = bus_io.req1;
        if (bus_io.req0 && bus_io.req1) begin
            winner = FixedPri ? 1'b0 : ~last_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            mem_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.req0 || bus_io.req1) begin
                        state_q        <= StIssue;
                        busy_q         <= 1'b1;
                        last_q         <= winner;
                        gnt_q[winner]  <= 1'b1;
                        mem_en_q       <= 1'b1;
                        mem_we_q       <= winner ? bus_io.we1    : bus_io.we0;
                        mem_addr_q     <= winner ? bus_io.addr1  : bus_io.addr0;
                        mem_wdata_q    <= winner ? bus_io.wdata1 : bus_io.wdata0;
                    end
                end
                StIssue: begin
                    if (mem_we_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    // Storage data is valid now; last_q still names the reader.
                    state_q          <= StIdle;
                    busy_q           <= 1'b0;
                    rvalid_q[last_q] <= 1'b1;
                    if (last_q) begin
                        rdata1_q <= bus_io.mem_rdata;
                    end else begin
                        rdata0_q <= bus_io.mem_rdata;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.gnt0      = gnt_q[0];
    assign bus_io.gnt1      = gnt_q[1];
    assign bus_io.rvalid0   = rvalid_q[0];
    assign bus_io.rvalid1   = rvalid_q[1];
    assign bus_io.rdata0    = rdata0_q;
    assign bus_io.rdata1    = rdata1_q;
    assign bus_io.mem_en    = mem_en_q;
    assign bus_io.mem_we    = mem_we_q;
    assign bus_io.mem_addr  = mem_addr_q;
    assign bus_io.mem_wdata = mem_wdata_q;
    assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_storage_access_arbiter.sv
// Scoreboard bench: bus 0 drives a round-robin arbiter, bus 1 a fixed-priority one,
// each with a one-cycle-latency storage model.
module tb_storage_access_arbiter;
    localparam int unsigned DataW = 32;
    localparam int unsigned AddrW = 6;

    typedef struct packed {
        int               cyc;
        logic             is_rd;
        logic             who;
        logic             busy;
        logic             we;
        logic [AddrW-1:0] addr;
        logic [DataW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic             req   [2][2];
    logic             we    [2][2];
    logic [AddrW-1:0] addr  [2][2];
    logic [DataW-1:0] wdata [2][2];

    wire             gnt    [2][2];
    wire             rvalid [2][2];
    wire [DataW-1:0] rdata  [2][2];
    wire             mem_en    [2];
    wire             mem_we    [2];
    wire             busy      [2];
    wire [AddrW-1:0] mem_addr  [2];
    wire [DataW-1:0] mem_wdata [2];

    ev_t exp_q [2][$];

    for (genvar g = 0; g < 2; g++) begin : g_bus
        storage_access_arbiter_if #(.DataW(DataW), .AddrW(AddrW)) bus ();
        logic [DataW-1:0] mem [64] = '{default: '0};
        logic [DataW-1:0] mem_rd = '0;

        assign bus.req0      = req[g][0];
        assign bus.req1      = req[g][1];
        assign bus.we0       = we[g][0];
        assign bus.we1       = we[g][1];
        assign bus.addr0     = addr[g][0];
        assign bus.addr1     = addr[g][1];
        assign bus.wdata0    = wdata[g][0];
        assign bus.wdata1    = wdata[g][1];
        assign bus.mem_rdata = mem_rd;
        assign gnt[g][0]     = bus.gnt0;
        assign gnt[g][1]     = bus.gnt1;
        assign rvalid[g][0]  = bus.rvalid0;
        assign rvalid[g][1]  = bus.rvalid1;
        assign rdata[g][0]   = bus.rdata0;
        assign rdata[g][1]   = bus.rdata1;
        assign mem_en[g]     = bus.mem_en;
        assign mem_we[g]     = bus.mem_we;
        assign mem_addr[g]   = bus.mem_addr;
        assign mem_wdata[g]  = bus.mem_wdata;
        assign busy[g]       = bus.busy;

        always @(posedge clk) begin
            if (bus.mem_en) begin
                if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
                else            mem_rd <= mem[bus.mem_addr];
            end
        end

        storage_access_arbiter #(
            .DataW    (DataW),
            .AddrW    (AddrW),
            .FixedPri (g == 1)
        ) dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .bus_io (bus)
        );
    end

    function automatic void expect_ev(input int b, input int c, input bit rd, input bit who,
                                      input bit w, input logic [AddrW-1:0] a,
                                      input logic [DataW-1:0] d);
        ev_t e;
        e.cyc   = c;
        e.is_rd = rd;
        e.who   = who;
        e.busy  = !rd;
        e.we    = rd ? 1'b0 : w;
        e.addr  = rd ? '0 : a;
        e.data  = d;
        exp_q[b].push_back(e);
    endfunction

    // Monitor: every grant/rvalid/mem_en cycle is matched against the next expected event.
    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            logic [3:0] hits;
            ev_t o;
            ev_t e;
            hits = {rvalid[b][1], rvalid[b][0], gnt[b][1], gnt[b][0]};
            if (hits != 4'b0 || mem_en[b]) begin
                checks++;
                if ($countones(hits) != 1 || mem_en[b] != (hits[0] | hits[1])) begin
                    errors++;
                    $display("FAIL excl bus%0d cyc %0d: got hits=%b mem_en=%b, required one pulse with mem_en only on grant",
                             b, cyc, hits, mem_en[b]);
                end else if (exp_q[b].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected bus%0d cyc %0d: got hits=%b, required no event", b, cyc, hits);
                end else begin
                    e       = exp_q[b].pop_front();
                    o.cyc   = cyc;
                    o.is_rd = hits[2] | hits[3];
                    o.who   = hits[1] | hits[3];
                    o.busy  = busy[b];
                    if (o.is_rd) begin
                        o.we   = 1'b0;
                        o.addr = '0;
                        o.data = rdata[b][o.who];
                    end else begin
                        o.we   = mem_we[b];
                        o.addr = mem_addr[b];
                        o.data = mem_wdata[b];
                    end
                    if (o !== e) begin
                        errors++;
                        $display("FAIL event bus%0d: got cyc=%0d rd=%0d who=%0d busy=%0d we=%0d addr=%h data=%h, required cyc=%0d rd=%0d who=%0d busy=%0d we=%0d addr=%h data=%h",
                                 b, o.cyc, o.is_rd, o.who, o.busy, o.we, o.addr, o.data,
                                 e.cyc, e.is_rd, e.who, e.busy, e.we, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic check_zero(input int b);
        logic [108:0] v;
        v = {gnt[b][0], gnt[b][1], rvalid[b][0], rvalid[b][1], rdata[b][0], rdata[b][1],
             mem_en[b], mem_we[b], mem_addr[b], mem_wdata[b], busy[b]};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset outputs bus%0d cyc %0d: got %h, required 0", b, cyc, v);
        end
    endtask

    task automatic do_reset(input bit with_req);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int b = 0; b < 2; b++) for (int w = 0; w < 2; w++) req[b][w] = with_req;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            for (int b = 0; b < 2; b++) check_zero(b);
        end
        for (int b = 0; b < 2; b++) for (int w = 0; w < 2; w++) req[b][w] = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic start(output int t);
        @(posedge clk);
        #1;
        t = cyc;
    endtask

    // Registered requester: holds Req until it sees Gnt, then moves on at the next edge.
    task automatic requester(input int b, input int who, input bit w,
                             input logic [AddrW-1:0] a0, input int step, input int n,
                             input logic [DataW-1:0] tag);
        for (int i = 0; i < n; i++) begin
            logic [AddrW-1:0] a;
            bit seen;
            a = AddrW'(int'(a0) + i * step);
            req[b][who]   = 1'b1;
            we[b][who]    = w;
            addr[b][who]  = a;
            wdata[b][who] = tag | DataW'(a);
            seen = 1'b0;
            for (int k = 0; k < 12 && !seen; k++) begin
                @(negedge clk);
                seen = gnt[b][who];
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL grant timeout bus%0d req%0d: got no Gnt in 12 cycles, required Gnt", b, who);
            end
            @(posedge clk);
            #1;
        end
        req[b][who] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time 100000, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 2; w++) begin
                req[b][w]   = 1'b0;
                we[b][w]    = 1'b0;
                addr[b][w]  = '0;
                wdata[b][w] = '0;
            end
        end

        // Reset with both requests held high
        do_reset(1'b1);

        // Single write then read on each requester
        start(t);
        expect_ev(0, t + 1, 0, 0, 1, 6'h03, 32'h0000_0003);
        requester(0, 0, 1'b1, 6'h03, 1, 1, 32'h0);
        start(t);
        expect_ev(0, t + 1, 0, 0, 0, 6'h03, 32'h0000_0003);
        expect_ev(0, t + 3, 1, 0, 0, 6'h00, 32'h0000_0003);
        requester(0, 0, 1'b0, 6'h03, 1, 1, 32'h0);
        start(t);
        expect_ev(0, t + 1, 0, 1, 1, 6'h2A, 32'hDEAD_BE2A);
        requester(0, 1, 1'b1, 6'h2A, 1, 1, 32'hDEAD_BE00);
        start(t);
        expect_ev(0, t + 1, 0, 1, 0, 6'h2A, 32'hDEAD_BE2A);
        expect_ev(0, t + 3, 1, 1, 0, 6'h00, 32'hDEAD_BE2A);
        requester(0, 1, 1'b0, 6'h2A, 1, 1, 32'hDEAD_BE00);

        // Round-robin contention, writes to 0..3
        do_reset(1'b0);
        start(t);
        expect_ev(0, t + 1, 0, 0, 1, 6'h00, 32'h0000_0100);
        expect_ev(0, t + 3, 0, 1, 1, 6'h01, 32'h0000_0101);
        expect_ev(0, t + 5, 0, 0, 1, 6'h02, 32'h0000_0102);
        expect_ev(0, t + 7, 0, 1, 1, 6'h03, 32'h0000_0103);
        fork
            requester(0, 0, 1'b1, 6'h00, 2, 2, 32'h0000_0100);
            requester(0, 1, 1'b1, 6'h01, 2, 2, 32'h0000_0100);
        join
        start(t);
        expect_ev(0, t + 1, 0, 1, 0, 6'h02, 32'h0000_0102);
        expect_ev(0, t + 3, 1, 1, 0, 6'h00, 32'h0000_0102);
        requester(0, 1, 1'b0, 6'h02, 1, 1, 32'h0000_0100);

        // Fixed priority: requester 1 only after requester 0 drops
        start(t);
        expect_ev(1, t + 1, 0, 0, 1, 6'h04, 32'h0000_0204);
        expect_ev(1, t + 3, 0, 0, 1, 6'h05, 32'h0000_0205);
        expect_ev(1, t + 5, 0, 0, 1, 6'h06, 32'h0000_0206);
        expect_ev(1, t + 7, 0, 1, 1, 6'h07, 32'h0000_0207);
        fork
            requester(1, 0, 1'b1, 6'h04, 1, 3, 32'h0000_0200);
            requester(1, 1, 1'b1, 6'h07, 1, 1, 32'h0000_0200);
        join

        // Reset while requester 1 read sits in the wait state
        start(t);
        expect_ev(0, t + 1, 0, 1, 0, 6'h2A, 32'hDEAD_BE2A);
        req[0][1]   = 1'b1;
        we[0][1]    = 1'b0;
        addr[0][1]  = 6'h2A;
        wdata[0][1] = 32'hDEAD_BE2A;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        req[0][1] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy in read wait: got %b, required 1", busy[0]);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || rvalid[0][1] !== 1'b0) begin
            errors++;
            $display("FAIL reset in read wait: got busy=%b rvalid1=%b, required 0 0",
                     busy[0], rvalid[0][1]);
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Addr/Wdata change during the grant cycle must not alter the write
        start(t);
        expect_ev(0, t + 1, 0, 1, 1, 6'h10, 32'hAAAA_0010);
        req[0][1]   = 1'b1;
        we[0][1]    = 1'b1;
        addr[0][1]  = 6'h10;
        wdata[0][1] = 32'hAAAA_0010;
        @(posedge clk);
        #1;
        addr[0][1]  = 6'h11;
        wdata[0][1] = 32'h5555_5555;
        @(posedge clk);
        #1;
        req[0][1] = 1'b0;
        start(t);
        expect_ev(0, t + 1, 0, 0, 0, 6'h10, 32'h0000_0010);
        expect_ev(0, t + 3, 1, 0, 0, 6'h00, 32'hAAAA_0010);
        requester(0, 0, 1'b0, 6'h10, 1, 1, 32'h0);
        start(t);
        expect_ev(0, t + 1, 0, 0, 0, 6'h11, 32'h0000_0011);
        expect_ev(0, t + 3, 1, 0, 0, 6'h00, 32'h0000_0000);
        requester(0, 0, 1'b0, 6'h11, 1, 1, 32'h0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            while (exp_q[b].size() != 0) begin
                ev_t e;
                e = exp_q[b].pop_front();
                checks++;
                errors++;
                $display("FAIL missing event bus%0d: got nothing, required rd=%0d who=%0d at cyc %0d",
                         b, e.is_rd, e.who, e.cyc);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
